// File: rtl/mod_msg_sched_pkg.sv
// -----------------------------------------------------------------------------
// mod_msg_sched_pkg
// Shared SHA-256 definitions for the message scheduler: word width, window
// depth, FSM state encoding, sigma rotate/shift amounts and a rotate helper.
// All words use [0:31] ordering, bit 0 being the MSB.
// -----------------------------------------------------------------------------
package mod_msg_sched_pkg;

   localparam int WORD_W    = 32;
   localparam int WIN_DEPTH = 16;
   localparam int IDX_W     = 6;

   // Small sigma amounts: s0 = ROTR7 ^ ROTR18 ^ SHR3, s1 = ROTR17 ^ ROTR19 ^ SHR10
   localparam int S0_R1 = 7;
   localparam int S0_R2 = 18;
   localparam int S0_SH = 3;
   localparam int S1_R1 = 17;
   localparam int S1_R2 = 19;
   localparam int S1_SH = 10;

   typedef logic [0:WORD_W-1] word_t;
   typedef logic [0:IDX_W-1]  idx_t;

   typedef enum logic {
      ST_LOAD   = 1'b0,
      ST_EXPAND = 1'b1
   } state_t;

   // Shifts act on the numeric value, so this is a true rotate toward the LSB
   // regardless of the [0:31] index direction.
   function automatic word_t rotr(input word_t x, input int n);
      return (x >> n) | (x << (WORD_W - n));
   endfunction

endpackage

// File: rtl/mod_s0.sv
// -----------------------------------------------------------------------------
// mod_s0
// SHA-256 small sigma-0 (combinational).
// Ports:
//   x : word in  [0:31], bit 0 = MSB
//   y : sigma0(x)
// -----------------------------------------------------------------------------
module mod_s0
   import mod_msg_sched_pkg::*;
(
   input  logic [0:WORD_W-1] x,
   output logic [0:WORD_W-1] y
);

   assign y = rotr(x, S0_R1) ^ rotr(x, S0_R2) ^ (x >> S0_SH);

endmodule

// File: rtl/mod_s1.sv
// -----------------------------------------------------------------------------
// mod_s1
// SHA-256 small sigma-1 (combinational).
// Ports:
//   x : word in  [0:31], bit 0 = MSB
//   y : sigma1(x)
// -----------------------------------------------------------------------------
module mod_s1
   import mod_msg_sched_pkg::*;
(
   input  logic [0:WORD_W-1] x,
   output logic [0:WORD_W-1] y
);

   assign y = rotr(x, S1_R1) ^ rotr(x, S1_R2) ^ (x >> S1_SH);

endmodule

// File: rtl/mod_msg_sched.sv
// -----------------------------------------------------------------------------
// mod_msg_sched
// SHA-256 message schedule generator. Loads 16 message words (W_0..W_15),
// then expands W_16..W_NROUNDS-1, emitting every W_t through a one-entry
// valid/ready output register.
// Ports:
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   in_valid  : in_data holds a message word
//   in_ready  : a message word is accepted this cycle
//   in_data   : message word [0:31], bit 0 = MSB
//   w_valid   : w_data / w_idx hold a schedule word
//   w_ready   : consumer takes the schedule word this cycle
//   w_data    : schedule word W_t
//   w_idx     : index t of w_data
//   blk_done  : pulse in the cycle W_(NROUNDS-1) is handed off
// -----------------------------------------------------------------------------
module mod_msg_sched
   import mod_msg_sched_pkg::*;
#(
   parameter int NROUNDS = 64   // legal 17..64
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [0:WORD_W-1] in_data,
   output logic              w_valid,
   input  logic              w_ready,
   output logic [0:WORD_W-1] w_data,
   output logic [0:IDX_W-1]  w_idx,
   output logic              blk_done
);

   localparam idx_t LAST_LOAD = IDX_W'(WIN_DEPTH - 1);
   localparam idx_t LAST_IDX  = IDX_W'(NROUNDS - 1);
   localparam idx_t IDX_ONE   = IDX_W'(1);

   state_t state, state_nxt;
   idx_t   cnt, cnt_nxt;          // index t of the next word to be registered
   word_t  win [WIN_DEPTH];       // win[k] = W_(t-1-k)
   logic   advance;               // output register free to take a new word
   logic   push;
   word_t  push_word;
   word_t  s0_y, s1_y, w_new;

   // Taps: W_(t-2) = win[1], W_(t-7) = win[6], W_(t-15) = win[14], W_(t-16) = win[15]
   mod_s0 u_s0 (.x(win[14]), .y(s0_y));
   mod_s1 u_s1 (.x(win[1]),  .y(s1_y));

   assign w_new   = s1_y + win[6] + s0_y + win[15];   // mod 2^32, carry dropped
   assign advance = !w_valid || w_ready;

   // The reset cycle is excluded so a handshake colliding with rst never
   // reports a completed block.
   assign blk_done = w_valid && w_ready && (w_idx == LAST_IDX) && !rst;

   // NOTE: every signal written here gets a default first, so no path leaves a
   // value unassigned and no latch can be inferred.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      push      = 1'b0;
      push_word = '0;
      in_ready  = (state == ST_LOAD) && advance;

      unique case (state)
         ST_LOAD: begin
            if (in_valid && in_ready) begin
               push      = 1'b1;
               push_word = in_data;
               cnt_nxt   = cnt + IDX_ONE;
               if (cnt == LAST_LOAD) begin
                  state_nxt = ST_EXPAND;
               end
            end
         end
         ST_EXPAND: begin
            // in_valid is deliberately ignored here.
            if (advance) begin
               push      = 1'b1;
               push_word = w_new;
               if (cnt == LAST_IDX) begin
                  cnt_nxt   = '0;
                  state_nxt = ST_LOAD;
               end else begin
                  cnt_nxt = cnt + IDX_ONE;
               end
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_LOAD;
         cnt     <= '0;
         w_valid <= 1'b0;
         w_data  <= '0;
         w_idx   <= '0;
         // NOTE: the window is a flop-based shift register, not a RAM, so it
         // can and does clear on reset; a partial block never leaks through.
         for (int i = 0; i < WIN_DEPTH; i++) begin
            win[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (push) begin
            win[0] <= push_word;
            for (int i = 1; i < WIN_DEPTH; i++) begin
               win[i] <= win[i-1];
            end
            w_data  <= push_word;
            w_idx   <= cnt;
            w_valid <= 1'b1;
         end else if (w_ready) begin
            w_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mod_msg_sched.sv
// -----------------------------------------------------------------------------
// tb_mod_msg_sched
// Self-checking bench for mod_msg_sched. Instance 0 uses NROUNDS=64,
// instance 1 uses NROUNDS=20. Expected schedule words come from a plain
// arithmetic SHA-256 schedule model; handshake timing comes from a
// produced/consumed word-count model of the block.
// -----------------------------------------------------------------------------
module tb_mod_msg_sched;

   localparam int NR0 = 64;
   localparam int NR1 = 20;

   logic        clk = 1'b0;
   logic        rst       [2];
   logic        in_valid  [2];
   logic        in_ready  [2];
   logic [0:31] in_data   [2];
   logic        w_valid   [2];
   logic        w_ready   [2];
   logic [0:31] w_data    [2];
   logic [0:5]  w_idx     [2];
   logic        blk_done  [2];

   int errors = 0;
   int checks = 0;

   logic [31:0] in_words [32];
   logic [31:0] exp_w    [128];
   logic [31:0] got_w    [128];

   always #5 clk = ~clk;

   mod_msg_sched #(.NROUNDS(NR0)) dut0 (
      .clk(clk), .rst(rst[0]),
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
      .w_valid(w_valid[0]), .w_ready(w_ready[0]), .w_data(w_data[0]),
      .w_idx(w_idx[0]), .blk_done(blk_done[0])
   );

   mod_msg_sched #(.NROUNDS(NR1)) dut1 (
      .clk(clk), .rst(rst[1]),
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
      .w_valid(w_valid[1]), .w_ready(w_ready[1]), .w_data(w_data[1]),
      .w_idx(w_idx[1]), .blk_done(blk_done[1])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---- reference model: SHA-256 schedule by plain arithmetic --------------
   function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
   endfunction

   task automatic build_exp(input int nr, input int nblk);
      for (int b = 0; b < nblk; b++) begin
         int o = b * nr;
         for (int t = 0; t < 16; t++) exp_w[o+t] = in_words[b*16+t];
         for (int t = 16; t < nr; t++)
            exp_w[o+t] = sig1(exp_w[o+t-2]) + exp_w[o+t-7] + sig0(exp_w[o+t-15]) + exp_w[o+t-16];
      end
   endtask

   task automatic set_abc(input int base);
      in_words[base] = 32'h6162_6380;
      for (int i = 1; i < 15; i++) in_words[base+i] = 32'h0;
      in_words[base+15] = 32'h0000_0018;
   endtask

   task automatic set_zero(input int base);
      for (int i = 0; i < 16; i++) in_words[base+i] = 32'h0;
   endtask

   task automatic set_rand(input int base);
      for (int i = 0; i < 16; i++) in_words[base+i] = $urandom;
   endtask

   // Drives nblk blocks into instance d and checks every cycle against the
   // model. Inputs change on the falling edge, outputs are sampled 1 ns later.
   // stop_after >= 0 aborts once W_(stop_after) has been handed off.
   task automatic run(input int d, input int nr, input int nblk, input bit bp,
                      input int stop_after, input string name);
      int produced  = 0;
      int consumed  = 0;
      int in_pos    = 0;
      int cyc       = 0;
      int pulses    = 0;
      int total_in  = 16 * nblk;
      int total_out = nr * nblk;
      bit m_valid, m_load, adv, rdy;
      while (consumed < total_out && cyc < 4000) begin
         @(negedge clk);
         in_valid[d] = (in_pos < total_in);
         if (in_pos < total_in) in_data[d] = in_words[in_pos];
         else                   in_data[d] = 32'hdead_beef;
         rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         w_ready[d] = rdy;
         #1;
         m_valid = produced > consumed;
         m_load  = (produced % nr) < 16;
         adv     = !m_valid || rdy;
         check({name, ".w_valid"}, 32'(w_valid[d]), 32'(m_valid));
         if (m_valid) begin
            check({name, ".w_data"}, w_data[d], exp_w[consumed]);
            check({name, ".w_idx"}, 32'(w_idx[d]), 32'(consumed % nr));
         end
         check({name, ".in_ready"}, 32'(in_ready[d]), 32'(m_load && adv));
         check({name, ".blk_done"}, 32'(blk_done[d]),
               32'(m_valid && rdy && (consumed % nr == nr - 1)));
         if (blk_done[d]) pulses++;
         if (m_valid && rdy) begin
            got_w[consumed] = w_data[d];
            consumed++;
         end
         if (m_load) begin
            if (in_valid[d] && adv) begin
               in_pos++;
               produced++;
            end
         end else if (adv) begin
            produced++;
         end
         cyc++;
         if (stop_after >= 0 && consumed > stop_after) break;
      end
      if (stop_after < 0) begin
         check({name, ".words_handed_off"}, 32'(consumed), 32'(total_out));
         check({name, ".blk_done_pulses"}, 32'(pulses), 32'(nblk));
      end else begin
         check({name, ".reached_abort_point"}, 32'(consumed), 32'(stop_after + 1));
      end
   endtask

   // After a finished block: output drained and block back in LOAD.
   task automatic idle_check(input int d, input string name);
      @(negedge clk);
      in_valid[d] = 1'b0;
      w_ready[d]  = 1'b1;
      #1;
      check({name, ".idle_w_valid"}, 32'(w_valid[d]), 32'h0);
      check({name, ".idle_in_ready"}, 32'(in_ready[d]), 32'h1);
      check({name, ".idle_blk_done"}, 32'(blk_done[d]), 32'h0);
   endtask

   task automatic reset_check(input int d, input string name);
      check({name, ".w_valid"}, 32'(w_valid[d]), 32'h0);
      check({name, ".w_data"}, w_data[d], 32'h0);
      check({name, ".w_idx"}, 32'(w_idx[d]), 32'h0);
      check({name, ".in_ready"}, 32'(in_ready[d]), 32'h1);
      check({name, ".blk_done"}, 32'(blk_done[d]), 32'h0);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d]      = 1'b1;
         in_valid[d] = 1'b0;
         in_data[d]  = '0;
         w_ready[d]  = 1'b0;
      end
      repeat (3) @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      #1;
      reset_check(0, "por0");
      reset_check(1, "por1");

      // "abc" block, no backpressure, plus known-answer spot checks
      set_abc(0);
      build_exp(NR0, 1);
      run(0, NR0, 1, 1'b0, -1, "abc");
      check("abc.W16", got_w[16], 32'h6162_6380);
      check("abc.W17", got_w[17], 32'h000F_0000);
      check("abc.W0", got_w[0], 32'h6162_6380);
      check("abc.W15", got_w[15], 32'h0000_0018);
      idle_check(0, "abc");

      // all-zero block
      set_zero(0);
      build_exp(NR0, 1);
      run(0, NR0, 1, 1'b0, -1, "zero");
      check("zero.W63", got_w[63], 32'h0);
      idle_check(0, "zero");

      // "abc" with random backpressure
      set_abc(0);
      build_exp(NR0, 1);
      run(0, NR0, 1, 1'b1, -1, "abc_bp");
      idle_check(0, "abc_bp");

      // random block with random backpressure
      set_rand(0);
      build_exp(NR0, 1);
      run(0, NR0, 1, 1'b1, -1, "rand_bp");
      idle_check(0, "rand_bp");

      // reset in the middle of expansion, then a clean "abc" block
      set_abc(0);
      build_exp(NR0, 1);
      run(0, NR0, 1, 1'b1, 30, "abort");
      @(negedge clk);
      rst[0]      = 1'b1;
      in_valid[0] = 1'b1;        // handshakes colliding with reset must lose
      in_data[0]  = 32'hffff_ffff;
      w_ready[0]  = 1'b1;
      #1;
      check("abort.blk_done_in_rst", 32'(blk_done[0]), 32'h0);
      @(negedge clk);
      rst[0]      = 1'b0;
      in_valid[0] = 1'b0;
      #1;
      reset_check(0, "mid_rst");
      run(0, NR0, 1, 1'b1, -1, "after_rst");
      idle_check(0, "after_rst");

      // two blocks back to back, in_valid held high through expansion
      set_abc(0);
      set_rand(16);
      build_exp(NR0, 2);
      run(0, NR0, 2, 1'b0, -1, "b2b");
      check("b2b.blk2_W0", got_w[64], in_words[16]);
      idle_check(0, "b2b");

      // short schedule: NROUNDS = 20
      set_abc(0);
      build_exp(NR1, 1);
      run(1, NR1, 1, 1'b1, -1, "nr20");
      check("nr20.W19", got_w[19], exp_w[19]);
      idle_check(1, "nr20");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mod_msg_sched.md
MOD_MSG_SCHED -- requirements
Module: MOD_MSG_SCHED

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 SHALL have parameter NROUNDS, default 64, number of schedule words per block; legal range 17..64.
REQ-003 SHALL have port CLK  in  1  rising-edge clock.
REQ-004 SHALL have port RST  in  1  synchronous active-high reset.
REQ-005 SHALL have port IN_VALID  in  1  IN_DATA holds a message word.
REQ-006 SHALL have port IN_READY  out  1  block accepts a message word this cycle.
REQ-007 SHALL have port IN_DATA  in  [0:31]  message word; bit 0 is the MSB.
REQ-008 SHALL have port W_VALID  out  1  W_DATA and W_IDX hold a schedule word.
REQ-009 SHALL have port W_READY  in  1  consumer takes the schedule word this cycle.
REQ-010 SHALL have port W_DATA  out  [0:31]  schedule word W_t; bit 0 is the MSB.
REQ-011 SHALL have port W_IDX  out  [0:5]  index t of W_DATA.
REQ-012 SHALL have port BLK_DONE  out  1  one-cycle pulse when word NROUNDS-1 is accepted.

Function
REQ-013 SHALL use FSM states LOAD and EXPAND; reset enters LOAD.
REQ-014 SHALL transfer a word on IN_VALID&&IN_READY and hand one off on W_VALID&&W_READY.
REQ-015 SHALL drive IN_READY = (state==LOAD) && (!W_VALID || W_READY), so the output register is never overwritten.
REQ-016 SHALL, in LOAD, register each accepted word into W_DATA on the next edge with W_IDX = count 0..15, and push it into a 16-entry window.
REQ-017 SHALL move LOAD->EXPAND on the edge that accepts word 15.
REQ-018 SHALL, in EXPAND, compute W_t = s1(W_t-2) + W_t-7 + s0(W_t-15) + W_t-16 modulo 2^32, with the carry discarded.
REQ-019 SHALL define s0 = ROTR7^ROTR18^SHR3 and s1 = ROTR17^ROTR19^SHR10.
REQ-020 SHALL produce one W_t per cycle while !W_VALID || W_READY, push it into the window, and register it with W_IDX = t.
REQ-021 SHALL hold W_DATA, W_IDX and W_VALID stable, and freeze the window and counter, while W_VALID && !W_READY.
REQ-022 SHALL generate no word with t >= NROUNDS; after W_t is generated for t = NROUNDS-1, it SHALL go to LOAD.
REQ-023 SHALL pulse BLK_DONE for exactly the cycle in which W_IDX = NROUNDS-1 is accepted.
REQ-024 SHALL allow back-to-back blocks: IN_READY may rise in the cycle the final word is handed off.
REQ-025 SHALL give a one-cycle latency from input acceptance to W_VALID; W_16 SHALL be valid the cycle after W_15 is handed off.
REQ-026 SHALL ignore IN_VALID while in EXPAND.

Reset
REQ-027 SHALL, on RST: state=LOAD, counter=0, W_VALID=0, BLK_DONE=0, W_DATA=0, W_IDX=0, window cleared.
REQ-028 SHALL discard any partial block when RST is asserted mid-LOAD or mid-EXPAND; the next accepted word is W_0.
REQ-029 SHALL give RST priority over simultaneous handshakes on the same edge.

Structure
REQ-030 SHALL place the word width (32), the window depth (16), the state encoding and the rotate/shift amounts in a shared SHA-256 package.
REQ-031 SHALL instantiate the existing MOD_S0 for s0 and a new combinational sub-module MOD_S1 for s1, using the same [0:31] port style.
REQ-032 SHALL implement the window as a shift register: no RAM, no per-round multiplexing beyond taps 2, 7, 15 and 16.

Verification
REQ-033 Bench SHALL apply "abc" padded block (W0=0x61626380, W1..W14=0, W15=0x00000018) -> W16=0x61626380, W17=0x000F0000, W0..W63 matching a software model, BLK_DONE once.
REQ-034 Bench SHALL apply an all-zero block -> all 64 W_DATA = 0, W_IDX counting 0..63.
REQ-035 Bench SHALL apply random W_READY backpressure (50%) during "abc" -> identical word sequence, no drops or duplicates, outputs stable while stalled.
REQ-036 Bench SHALL assert RST after W_IDX=30, then send the "abc" block -> W_VALID=0 after reset, first output W_IDX=0, full correct sequence.
REQ-037 Bench SHALL send two blocks back-to-back with IN_VALID held high -> IN_READY low during EXPAND, the second block starts at W_IDX=0 immediately after BLK_DONE.
REQ-038 Bench SHALL run NROUNDS=20 with "abc" -> last W_IDX=19, BLK_DONE pulses then, and LOAD is re-entered.
